// File: rtl/dec_stage_pipe.sv
// Pipelined decode stage: field decode, register file with write-back bypass,
// per-register pending scoreboard for RAW/WAW stalls, and a one-entry output buffer.
module dec_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_inst,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_op,
  output logic [3:0]        out_rd,
  output logic              out_rd_wr,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_pnz,
  output logic [DATA_W-1:0] out_pc,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              illegal,
  output logic              halted
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_HALT = 4'h1, OP_SUB = 4'h2, OP_ADD = 4'h3,
    OP_BRR = 4'h4, OP_BR   = 4'h5, OP_LD  = 4'h6, OP_ST  = 4'h7,
    OP_PLY = 4'h8, OP_MV   = 4'h9, OP_BSL = 4'hA, OP_BSH = 4'hB,
    OP_RET = 4'hC, OP_SES  = 4'hD, OP_STB = 4'hE, OP_LDB = 4'hF
  } opcode_e;

  function automatic logic reg_ok(input logic [3:0] a);
    return int'(a) < NREGS;
  endfunction

  // A pending register stops blocking in the same cycle its write-back arrives.
  function automatic logic busy(input logic [15:0] pend, input logic [3:0] a,
                                input logic we, input logic [3:0] wa);
    return pend[a] & ~(we & (wa == a));
  endfunction

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic              run_q, out_valid_q, out_valid_d, illegal_q, halted_q, halted_d;
  logic              out_rd_wr_q;
  logic [15:0]       out_op_q;
  logic [3:0]        out_rd_q;
  logic [DATA_W-1:0] out_rs1_q, out_rs2_q, out_imm_q, out_pc_q;
  logic [2:0]        out_pnz_q;

  opcode_e           opc_s;
  logic              use_rd_s, use_rs1_s, use_rs2_s, rs2_hi_s, is_br_s;
  logic [3:0]        rd_s, rs1_s, rs2_s;
  logic [DATA_W-1:0] imm_s, rf1_s, rf2_s, rs1_val_s, rs2_val_s;
  logic [15:0]       pend16_s;
  logic              illegal_s, hazard_s, in_ready_s, acc_s, load_s;

  // Field decode of the incoming instruction
  always_comb begin
    opc_s     = opcode_e'(in_inst[15:12]);
    use_rd_s  = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    rs2_hi_s  = 1'b0;
    is_br_s   = 1'b0;
    imm_s     = '0;
    case (opc_s)
      OP_ADD, OP_SUB: begin
        use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      OP_LD: begin
        use_rd_s = 1'b1; use_rs1_s = 1'b1;
        imm_s = {{(DATA_W-4){in_inst[3]}}, in_inst[3:0]};
      end
      OP_ST: begin
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; rs2_hi_s = 1'b1;
        imm_s = {{(DATA_W-4){in_inst[3]}}, in_inst[3:0]};
      end
      OP_BR: begin
        is_br_s = 1'b1;
        imm_s = {{(DATA_W-9){in_inst[8]}}, in_inst[8:0]};
      end
      OP_BRR: begin
        is_br_s = 1'b1; use_rs1_s = 1'b1;
        imm_s = {{(DATA_W-4){in_inst[3]}}, in_inst[3:0]};
      end
      OP_MV, OP_BSL, OP_BSH: begin
        use_rd_s = 1'b1;
        imm_s = {{(DATA_W-8){in_inst[7]}}, in_inst[7:0]};
      end
      OP_PLY, OP_RET, OP_SES: begin
        use_rs1_s = 1'b1;
      end
      OP_STB: begin
        use_rs1_s = 1'b1;
        imm_s = {{(DATA_W-6){in_inst[5]}}, in_inst[5:0]};
      end
      OP_LDB: begin
        use_rd_s = 1'b1; use_rs1_s = 1'b1;
        imm_s = {{(DATA_W-6){in_inst[5]}}, in_inst[5:0]};
      end
      default: begin
        use_rd_s = 1'b0;
      end
    endcase
    rd_s  = in_inst[11:8];
    rs1_s = in_inst[7:4];
    if (rs2_hi_s) begin
      rs2_s = in_inst[11:8];
    end else begin
      rs2_s = in_inst[3:0];
    end
  end

  // Register file read with same-cycle write-back bypass
  always_comb begin
    rf1_s = '0;
    rf2_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      rf1_s = (rs1_s == 4'(i)) ? regs_q[i] : rf1_s;
      rf2_s = (rs2_s == 4'(i)) ? regs_q[i] : rf2_s;
    end
    rs1_val_s = (wb_en && (wb_addr == rs1_s)) ? wb_data : rf1_s;
    rs2_val_s = (wb_en && (wb_addr == rs2_s)) ? wb_data : rf2_s;
  end

  // Scoreboard view widened to the full 4-bit address space
  always_comb begin
    pend16_s = 16'd0;
    for (int i = 0; i < NREGS; i++) begin
      pend16_s[i] = pend_q[i];
    end
  end

  assign illegal_s = (use_rd_s  & ~reg_ok(rd_s))  |
                     (use_rs1_s & ~reg_ok(rs1_s)) |
                     (use_rs2_s & ~reg_ok(rs2_s));
  assign hazard_s  = (use_rs1_s & busy(pend16_s, rs1_s, wb_en, wb_addr)) |
                     (use_rs2_s & busy(pend16_s, rs2_s, wb_en, wb_addr)) |
                     (use_rd_s  & busy(pend16_s, rd_s,  wb_en, wb_addr));
  assign in_ready_s = run_q & ~halted_q & ~flush & ~hazard_s &
                      ~(out_valid_q & out_op_q[1]) & (~out_valid_q | out_ready);
  assign acc_s  = in_valid & in_ready_s;
  assign load_s = acc_s & ~illegal_s;

  // Scoreboard next state: clears first, so a same-register set wins
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      pend_d[i] = (load_s & use_rd_s & (rd_s == 4'(i))) |
                  (pend_q[i] &
                   ~(wb_en & (wb_addr == 4'(i))) &
                   ~(flush & out_valid_q & out_rd_wr_q & (out_rd_q == 4'(i))));
    end
  end

  // Output-buffer occupancy and the sticky halt
  always_comb begin
    halted_d = halted_q | (out_valid_q & out_ready & out_op_q[1] & ~flush);
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_s) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      pend_q      <= '0;
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      pend_q      <= pend_d;
      illegal_q   <= acc_s & illegal_s;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Bundle payload registers; unused operand fields load as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_op_q    <= 16'd0;
      out_rd_q    <= 4'd0;
      out_rd_wr_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_imm_q   <= '0;
      out_pnz_q   <= 3'd0;
      out_pc_q    <= '0;
    end else if (load_s) begin
      out_op_q    <= 16'd1 << in_inst[15:12];
      out_rd_q    <= use_rd_s ? rd_s : 4'd0;
      out_rd_wr_q <= use_rd_s;
      out_rs1_q   <= use_rs1_s ? rs1_val_s : '0;
      out_rs2_q   <= use_rs2_s ? rs2_val_s : '0;
      out_imm_q   <= imm_s;
      out_pnz_q   <= is_br_s ? in_inst[11:9] : 3'd0;
      out_pc_q    <= in_pc;
    end
  end

  // Register file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (wb_addr == 4'(i))) begin
          regs_q[i] <= wb_data;
        end
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_q;
  assign out_op       = out_op_q;
  assign out_rd       = out_rd_q;
  assign out_rd_wr    = out_rd_wr_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;
  assign out_imm      = out_imm_q;
  assign out_pnz      = out_pnz_q;
  assign out_pc       = out_pc_q;
  assign illegal      = illegal_q;
  assign halted       = halted_q;

endmodule

// File: doc/dec_stage_pipe.md
# dec_stage_pipe

Parametrised, pipelined successor to the CPU decode stage. It accepts 16-bit instructions from fetch over a valid/ready handshake and decodes them into a one-hot op vector, register operands and a sign-extended immediate. It holds a DATA_W-wide register file with write-back bypass, and a scoreboard that stalls RAW/WAW hazards. Results are registered into a one-entry output buffer feeding execute, and the block supports flush and HALT.

## Interface
- DATA_W, 16: register/immediate/PC width; legal range ≥16.
- NREGS, 16: implemented registers; legal range 2..16 (4-bit address fields).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_inst  in  16  instruction.
- in_pc  in  DATA_W  PC of in_inst.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_op  out  16  one-hot, bit = opcode.
- out_rd  out  4  destination register.
- out_rd_wr  out  1  bundle writes out_rd.
- out_rs1_data, out_rs2_data  out  DATA_W  operand values.
- out_imm  out  DATA_W  sign-extended immediate.
- out_pnz  out  3  branch condition inst[11:9].
- out_pc  out  DATA_W  PC of the bundle.
- wb_en  in  1  register write-back.
- wb_addr  in  4  write-back register.
- wb_data  in  DATA_W  write-back value.
- flush  in  1  kill the held bundle and block input this cycle.
- illegal  out  1  one-cycle pulse when an instruction is dropped.
- halted  out  1  sticky; set once HALT leaves decode.

## Operation
- Opcode field: inst[15:12]. Encoding: 0 NOP, 1 HALT, 2 SUB, 3 ADD, 4 BRR, 5 BR, 6 LD, 7 ST, 8 PLY, 9 MV, A BSL, B BSH, C RET, D SES, E STB, F LDB.
- Fields per opcode:
  - ADD/SUB: rd=[11:8], rs1=[7:4], rs2=[3:0]; writes rd.
  - LD: rd=[11:8], rs1=[7:4], imm=se4[3:0]; writes rd.
  - ST: rs2=[11:8], rs1=[7:4], imm=se4.
  - BR: imm=se9[8:0]. BRR: rs1=[7:4], imm=se4.
  - MV/BSL/BSH: rd=[11:8], imm=se8[7:0]; write rd.
  - PLY/RET/SES: rs1=[7:4].
  - STB/LDB: rs1=[7:4], imm=se6[5:0]; LDB writes rd=[11:8].
  - NOP/HALT: no operands.
  - Unused operand outputs: 0.
- Sign extension replicates the field MSB up to DATA_W.
- Register file: NREGS×DATA_W, every register resets to 0. Written at the clock edge when wb_en=1 and wb_addr<NREGS; a wb_addr≥NREGS is ignored. Reads are combinational. A same-cycle write to a read address is bypassed, so the operand takes wb_data.
- Illegal: any used register field ≥NREGS. On accept the instruction is consumed and no bundle is produced. illegal pulses the next cycle, and pending is unchanged.
- Scoreboard: one pending bit per register.
  - Set on accept of a writing instruction.
  - Cleared when wb_en hits that address.
  - Set and clear in the same cycle on the same register: set wins.
- Hazard: any used source, or the rd of a writing instruction, is pending and not being written back this cycle.
- in_ready = !halted & !flush & !hazard & !(out_valid & out_op[1]) & (!out_valid | out_ready).
- flush: clears out_valid. If the held bundle has out_rd_wr=1, its pending bit is cleared; a same-cycle accept cannot occur.
- HALT: while held, it blocks input. On its consumption (out_valid & out_ready), halted is set and stays set until reset. A flushed HALT never sets halted.

## Timing
- Latency: one cycle from accept to out_valid.
- Output registers hold while out_valid & !out_ready.
- Bypass and hazard checks are same-cycle; a stall releases in the cycle wb clears the last blocking bit.
- Reset (asynchronous, rst_n=0): all outputs 0; pending all 0; registers 0; halted 0; in_ready 0 during reset.
- Reset mid-operation discards the held bundle and all pending state.
- Back-to-back throughput: one instruction per cycle absent hazards and with out_ready=1.

## Test plan
- ADD r3,r1,r2 with r1=5, r2=7 preloaded via wb -> next cycle out_op[3]=1, out_rd=3, out_rs1_data=5, out_rs2_data=7, out_rd_wr=1.
- ADD r3,… then SUB r4,r3,r1 -> SUB stalls (in_ready=0). wb_en, r3=0x000C in the same cycle as the stall -> SUB accepted that cycle with out_rs1_data=0x000C.
- BR with [8:0]=0x1FF, DATA_W=32 -> out_imm=0xFFFFFFFF. MV imm 0x7F -> out_imm=0x0000007F. STB imm 0x20 -> out_imm=0xFFFFFFE0.
- NREGS=8, ADD r9,r1,r2 -> illegal pulses once, no out_valid, pending[9] unaffected, next instruction proceeds.
- LD r5 held with out_ready=0, then flush -> out_valid=0, pending[5]=0. A following ADD r6,r5,r5 is accepted without stall.
- HALT consumed -> halted=1 and in_ready=0 thereafter. HALT flushed before consumption -> halted=0, fetch resumes. rst_n low mid-stream -> all outputs 0 immediately.
